// File: rtl/led_seq_pkg.sv
// Shared encodings and the per-tick pattern step function for led_seq.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef struct packed {
    logic [7:0] pat;
    dir_e       dir;
  } step_t;

  // Pattern and bounce direction after one prescaler tick.
  function automatic step_t next_step(input mode_e m, input logic [7:0] p, input dir_e d);
    step_t s;
    s.pat = p;
    s.dir = d;
    case (m)
      MODE_ROTATE: s.pat = {p[6:0], p[7]};
      MODE_BOUNCE: begin
        if (d == DIR_LEFT) begin
          if (p == 8'h80) begin
            s.pat = 8'h40;
            s.dir = DIR_RIGHT;
          end else begin
            s.pat = {p[6:0], 1'b0};
          end
        end else begin
          if (p == 8'h01) begin
            s.pat = 8'h02;
            s.dir = DIR_LEFT;
          end else begin
            s.pat = {1'b0, p[7:1]};
          end
        end
      end
      MODE_COUNT:  s.pat = p + 8'd1;
      MODE_STATIC: s.pat = p;
      default:     s.pat = p;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step prescaler: counts 0..DIV-1 while EN, TICK on the last count, cleared while EN=0.
module led_prescaler #(
  parameter int unsigned DIV = 3000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!EN || (cnt_q == LAST)) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/led_seq.sv
// LED pattern sequencer (rotate/bounce/count/static). Optional step limit with
// STEPS/DONE ports is enabled by defining LED_SEQ_LIMIT_EN.
module led_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned DIV = 3000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic [1:0] MODE,
  input  logic [7:0] PAT,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       LED6,
  output logic       LED7,
  output logic       BUSY
`ifdef LED_SEQ_LIMIT_EN
  ,
  input  logic [7:0] STEPS,
  output logic       DONE
`endif
);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  dir_e       dir_q, dir_d;
  logic [7:0] led_q, led_d;
  logic       tick;
  step_t      nxt;
`ifdef LED_SEQ_LIMIT_EN
  logic [7:0] steps_q, steps_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       done_q, done_d;
`endif

  led_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (state_q == ST_RUN),
    .TICK (tick)
  );

  assign nxt = next_step(mode_q, led_q, dir_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
`ifdef LED_SEQ_LIMIT_EN
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    done_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        led_d = '0;
        dir_d = DIR_LEFT;
        // STOP in the same cycle drops the START request.
        if (START && !STOP) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(MODE);
          led_d   = (mode_e'(MODE) == MODE_BOUNCE) ? 8'h01 : PAT;
`ifdef LED_SEQ_LIMIT_EN
          steps_d    = STEPS;
          step_cnt_d = '0;
`endif
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_d = ST_IDLE;
          led_d   = '0;
        end else if (tick) begin
          led_d = nxt.pat;
          dir_d = nxt.dir;
`ifdef LED_SEQ_LIMIT_EN
          step_cnt_d = step_cnt_q + 8'd1;
          if ((steps_q != 8'd0) && (step_cnt_q == steps_q - 8'd1)) begin
            state_d = ST_IDLE;
            led_d   = '0;
            done_d  = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ROTATE;
      dir_q   <= DIR_LEFT;
      led_q   <= '0;
`ifdef LED_SEQ_LIMIT_EN
      steps_q    <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
`ifdef LED_SEQ_LIMIT_EN
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
`endif
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led_q;
  assign BUSY = (state_q == ST_RUN);
`ifdef LED_SEQ_LIMIT_EN
  assign DONE = done_q;
`endif

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 SHALL have parameter DIV, default 3000000, meaning CLK cycles per pattern step (12 MHz CLK gives 4 steps/s); legal DIV >= 2.
REQ-002 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  single-cycle request to begin a sequence.
REQ-005 SHALL have port STOP  input  1  single-cycle request to abort the sequence.
REQ-006 SHALL have port MODE  input  2  sequence selector, sampled on accepted START.
REQ-007 SHALL have port PAT  input  8  seed pattern, sampled on accepted START.
REQ-008 SHALL have ports LED0..LED7  output  1 each  registered pattern bits 0..7, driving the board LEDs.
REQ-009 SHALL have port BUSY  output  1  high while in RUN.

Function
REQ-010 SHALL implement FSM states IDLE and RUN only.
REQ-011 SHALL, in IDLE, hold all LEDs at 0 and BUSY at 0.
REQ-012 SHALL accept START only in IDLE; the next cycle is RUN with mode and seed latched, BUSY=1, LEDs = initial pattern, prescaler = 0.
REQ-013 SHALL ignore START while in RUN, leaving the latched mode and pattern unchanged.
REQ-014 SHALL make STOP in RUN force IDLE on the next edge; STOP and START in the same IDLE cycle: STOP wins and START is dropped.
REQ-015 SHALL have a prescaler that counts 0..DIV-1 in RUN only and wraps; tick is asserted on the cycle count == DIV-1, and the pattern updates on that edge, so the first update occurs DIV cycles after entering RUN.
REQ-016 SHALL implement MODE=0 ROTATE: initial = PAT, each tick rotate left by 1 (bit7 -> bit0); PAT=0x00 stays 0x00.
REQ-017 SHALL implement MODE=1 BOUNCE: initial = 0x01 with direction left, ignoring PAT; shift one position per tick; at 0x80 the next value is 0x40 and direction becomes right; at 0x01 moving right, the next value is 0x02 and direction becomes left.
REQ-018 SHALL implement MODE=2 COUNT: initial = PAT, +1 modulo 256 per tick; 0xFF wraps to 0x00.
REQ-019 SHALL implement MODE=3 STATIC: initial = PAT, held unchanged on ticks.
REQ-020 SHALL keep all outputs glitch-free, driven directly from flops.

Reset
REQ-021 SHALL, on RST=1 at any time including mid-sequence, immediately set IDLE, LEDs = 0x00, BUSY = 0, prescaler = 0, direction = left, and the step counter to 0.
REQ-022 SHALL resume operation only on a START seen after RST deasserts.

Configuration
REQ-023 SHALL use macro LED_SEQ_LIMIT_EN; when defined, it adds input STEPS (8 bits, sampled with START) and output DONE (1 bit).
REQ-024 SHALL, with LED_SEQ_LIMIT_EN defined and STEPS != 0, return to IDLE on the edge of the STEPS-th tick and pulse DONE high for exactly 1 cycle in that same cycle; STEPS = 0 means unlimited; STOP aborts without DONE.
REQ-025 SHALL, without LED_SEQ_LIMIT_EN, omit the STEPS and DONE ports and the step counter, and run until STOP or RST.

Structure
REQ-026 SHALL place the mode encodings (ROTATE=0, BOUNCE=1, COUNT=2, STATIC=3) and the state encodings in shared package led_seq_pkg.
REQ-027 SHALL implement the prescaler as sub-module led_prescaler (params DIV; ports CLK, RST, EN, TICK), cleared while EN=0.

Verification (bench DIV=4)
REQ-028 SHALL cover: START with MODE=0, PAT=0x81 -> LEDs 0x81; after 4 cycles 0x03; after 8 cycles 0x06; BUSY=1 throughout.
REQ-029 SHALL cover: START with MODE=1 -> LEDs step 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02 every 4 cycles.
REQ-030 SHALL cover: START with MODE=2, PAT=0xFE -> LEDs 0xFE, 0xFF, 0x00, 0x01 at 4-cycle intervals.
REQ-031 SHALL cover: STOP and START asserted together in IDLE -> remains IDLE; then START with MODE=3, PAT=0x5A, followed by STOP at cycle 6 -> LEDs 0x5A, then 0x00 and BUSY=0 on the next edge.
REQ-032 SHALL cover: RST pulse mid-COUNT at pattern 0x37 -> LEDs 0x00 and BUSY=0 asynchronously; a following START with PAT=0x10 restarts at 0x10.
REQ-033 SHALL cover, with LED_SEQ_LIMIT_EN: STEPS=3, MODE=2, PAT=0x00 -> 0x00, 0x01, 0x02, then IDLE and a 1-cycle DONE pulse at cycle 12.
